// File: rtl/opcode_loader.sv
// -----------------------------------------------------------------------------
// opcode_loader
//
// Sequencing controller for the GPU's 3-word opcode shift register. Takes
// instruction words from the command FIFO, drives the opcode register's shift
// strobe and serial input, and holds opcode_valid once a full opcode has been
// shifted in, until the decoder accepts it.
//
// Handshake: a word moves on a rising clk edge where word_valid && word_ready.
// word_ready never depends on state registered later than state_q, and
// shift_enable is exactly that transfer condition, so the FIFO pop and the
// register shift always happen on the same edge.
//
// Ports:
//   clk            system clock, all state changes on the rising edge
//   n_rst          asynchronous active-low reset
//   word_valid     FIFO presents a word on word_in
//   word_in        instruction word (WORD_W bits)
//   word_ready     loader takes word_in this cycle (combinational)
//   shift_enable   shift strobe to the opcode register (= word_valid && word_ready)
//   serial_out     pass-through of word_in to the register's serial_in
//   opcode_valid   register holds a complete opcode (registered)
//   opcode_accept  decoder consumes the opcode (ignored unless opcode_valid)
//   flush          synchronous abort of any partial or complete opcode
//   word_count     words held in the current partial opcode, 0..2 (registered)
//   op_count       opcodes accepted since reset, wraps at 16 bits (registered)
//   frame_error    one-cycle pulse when a partial opcode times out (registered)
//   state_dbg      current FSM state, for observation only
//
// Build option:
//   OPCODE_LOADER_TIMEOUT_EN  when defined, a partial opcode left idle for more
//                             than TIMEOUT_CYCLES cycles is discarded and
//                             frame_error pulses. When undefined, partial
//                             opcodes wait indefinitely and frame_error is 0.
// -----------------------------------------------------------------------------
module opcode_loader #(
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_OP   = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_in,
  output logic              word_ready,
  output logic              shift_enable,
  output logic [WORD_W-1:0] serial_out,
  output logic              opcode_valid,
  input  logic              opcode_accept,
  input  logic              flush,
  output logic [1:0]        word_count,
  output logic [15:0]       op_count,
  output logic              frame_error,
  output logic [1:0]        state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // Count value at which the next transfer completes the opcode.
  localparam logic [1:0]  LAST_CNT  = 2'(WORDS_PER_OP - 1);
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        opcode_valid_q, opcode_valid_d;
  logic [15:0] op_count_q, op_count_d;
  logic        frame_error_q, frame_error_d;
  logic [15:0] tmo_q, tmo_d;
  logic        xfer;

  // ---------------------------------------------------------------------------
  // Combinational handshake. In FULL a new word may only enter on the edge
  // where the decoder takes the old opcode, which gives bubble-free
  // back-to-back opcodes. Flush blocks every transfer.
  // ---------------------------------------------------------------------------
  always_comb begin
    word_ready = 1'b0;
    if (state_q == ST_FULL) begin
      word_ready = opcode_accept && !flush;
    end else begin
      word_ready = !flush;
    end
  end

  assign xfer         = word_valid && word_ready;
  assign shift_enable = xfer;
  assign serial_out   = word_in;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    op_count_d    = op_count_q;
    frame_error_d = 1'b0;
    tmo_d         = tmo_q;

    if (flush) begin
      // Flush wins over transfer and accept; register contents stay stale.
      state_d = ST_IDLE;
      count_d = 2'd0;
      tmo_d   = 16'd0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (xfer) begin
            state_d = ST_LOAD;
            count_d = 2'd1;
          end
        end

        ST_LOAD: begin
          if (xfer) begin
            tmo_d = 16'd0;
            if (count_q == LAST_CNT) begin
              state_d = ST_FULL;
              count_d = 2'd0;
            end else begin
              count_d = count_q + 2'd1;
            end
          end else begin
`ifdef OPCODE_LOADER_TIMEOUT_EN
            // The limit is reached after TIMEOUT_CYCLES idle edges; the edge
            // after that drops the partial opcode.
            if (tmo_q == TMO_LIMIT) begin
              state_d       = ST_IDLE;
              count_d       = 2'd0;
              tmo_d         = 16'd0;
              frame_error_d = 1'b1;
            end else begin
              tmo_d = tmo_q + 16'd1;
            end
`endif
          end
        end

        ST_FULL: begin
          if (opcode_accept) begin
            op_count_d = op_count_q + 16'd1;
            if (xfer) begin
              state_d = ST_LOAD;
              count_d = 2'd1;
            end else begin
              state_d = ST_IDLE;
              count_d = 2'd0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
          count_d = 2'd0;
        end
      endcase
    end

    // The idle counter only runs while a partial opcode is held.
    if (state_d != ST_LOAD) begin
      tmo_d = 16'd0;
    end

    opcode_valid_d = (state_d == ST_FULL);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= ST_IDLE;
      count_q        <= 2'd0;
      opcode_valid_q <= 1'b0;
      op_count_q     <= 16'd0;
      frame_error_q  <= 1'b0;
      tmo_q          <= 16'd0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      opcode_valid_q <= opcode_valid_d;
      op_count_q     <= op_count_d;
      frame_error_q  <= frame_error_d;
      tmo_q          <= tmo_d;
    end
  end

  assign opcode_valid = opcode_valid_q;
  assign word_count   = count_q;
  assign op_count     = op_count_q;
  assign state_dbg    = state_q;

`ifdef OPCODE_LOADER_TIMEOUT_EN
  assign frame_error = frame_error_q;
`else
  // Without the timeout the counter and error flop stay at reset values and
  // are dropped by synthesis.
  assign frame_error = 1'b0;
  logic unused_tmo;
  assign unused_tmo = frame_error_q ^ (^tmo_q) ^ (^TMO_LIMIT);
`endif

endmodule

// File: tb/tb_opcode_loader.sv
// -----------------------------------------------------------------------------
// tb_opcode_loader
//
// Bench for opcode_loader. The reference model holds the words of the opcode
// currently being built in a queue: its size is the number of words held
// (3 = complete opcode waiting for the decoder). Directed sequences follow the
// intended use cases, then a long randomized run exercises everything together.
// -----------------------------------------------------------------------------
module tb_opcode_loader;

  localparam int WORD_W = 32;
  localparam int TMO    = 4;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              n_rst;
  logic              word_valid;
  logic [WORD_W-1:0] word_in;
  logic              word_ready;
  logic              shift_enable;
  logic [WORD_W-1:0] serial_out;
  logic              opcode_valid;
  logic              opcode_accept;
  logic              flush;
  logic [1:0]        word_count;
  logic [15:0]       op_count;
  logic              frame_error;
  logic [1:0]        state_dbg;

  always #5 clk = ~clk;

  opcode_loader #(
    .WORD_W        (WORD_W),
    .WORDS_PER_OP  (3),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .word_valid   (word_valid),
    .word_in      (word_in),
    .word_ready   (word_ready),
    .shift_enable (shift_enable),
    .serial_out   (serial_out),
    .opcode_valid (opcode_valid),
    .opcode_accept(opcode_accept),
    .flush        (flush),
    .word_count   (word_count),
    .op_count     (op_count),
    .frame_error  (frame_error),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model
  // ---------------------------------------------------------------------------
  logic [WORD_W-1:0] exp_q[$];   // words of the opcode being assembled
  logic [15:0]       op_exp;
  logic              fe_exp;
  int                idle_cnt;
  int                n_checks;
  int                n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    op_exp   = 16'd0;
    fe_exp   = 1'b0;
    idle_cnt = 0;
  endtask

  // Expected observable values derived from the queue of held words.
  function automatic logic exp_ready(input logic acc, input logic fl);
    if (exp_q.size() == 3) return acc && !fl;
    return !fl;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver: one clock cycle with the given inputs. Inputs change on the
  // falling edge, outputs are checked 1 time unit later, model advances on the
  // rising edge.
  // ---------------------------------------------------------------------------
  task automatic step(input logic v, input logic [WORD_W-1:0] w,
                      input logic acc, input logic fl);
    logic rdy;
    logic xfer;
    int   held;
    @(negedge clk);
    word_valid    = v;
    word_in       = w;
    opcode_accept = acc;
    flush         = fl;
    #1;
    held = exp_q.size();
    rdy  = exp_ready(acc, fl);
    xfer = v && rdy;
    check("word_ready",   32'(word_ready),   32'(rdy));
    check("shift_enable", 32'(shift_enable), 32'(xfer));
    check("serial_out",   serial_out,        w);
    check("word_count",   32'(word_count),   (held == 3) ? 32'd0 : 32'(held));
    check("opcode_valid", 32'(opcode_valid), 32'(held == 3));
    check("op_count",     32'(op_count),     32'(op_exp));
    check("frame_error",  32'(frame_error),  32'(fe_exp));

    @(posedge clk);
    fe_exp = 1'b0;
    if (fl) begin
      exp_q.delete();
    end else if (held == 3) begin
      if (acc) begin
        op_exp = op_exp + 16'd1;
        exp_q.delete();
        if (xfer) exp_q.push_back(w);
      end
    end else if (xfer) begin
      exp_q.push_back(w);
      idle_cnt = 0;
    end else if (held > 0) begin
`ifdef OPCODE_LOADER_TIMEOUT_EN
      if (idle_cnt == TMO) begin
        exp_q.delete();
        fe_exp = 1'b1;
      end else begin
        idle_cnt++;
      end
`endif
    end
    if (exp_q.size() == 0 || exp_q.size() == 3) idle_cnt = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks      = 0;
    n_pass        = 0;
    word_valid    = 1'b0;
    word_in       = '0;
    opcode_accept = 1'b0;
    flush         = 1'b0;
    n_rst         = 1'b0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check("rst_word_count",   32'(word_count),   32'd0);
    check("rst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("rst_op_count",     32'(op_count),     32'd0);
    check("rst_word_ready",   32'(word_ready),   32'd1);
    @(negedge clk);
    n_rst = 1'b1;

    // Three words form an opcode, then it sits in FULL with no accept.
    step(1'b1, 32'hA, 1'b0, 1'b0);
    step(1'b1, 32'hB, 1'b0, 1'b0);
    step(1'b1, 32'hC, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b0);
    step(1'b1, 32'hD, 1'b0, 1'b0);

    // Accept held with back-to-back words: no bubble on the accept edge.
    step(1'b1, 32'hD, 1'b1, 1'b0);
    step(1'b1, 32'hE, 1'b1, 1'b0);
    step(1'b1, 32'hF, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    check("op_count_after_accept", 32'(op_count), 32'd1);

    // FULL with accept and flush together: flush wins, op_count unchanged.
    step(1'b1, 32'h11, 1'b1, 1'b1);
    step(1'b0, 32'h0,  1'b0, 1'b0);
    check("flush_keeps_op_count", 32'(op_count), 32'd1);

    // Flush after two words with word_valid high: no shift, fresh opcode.
    step(1'b1, 32'h21, 1'b0, 1'b0);
    step(1'b1, 32'h22, 1'b0, 1'b0);
    step(1'b1, 32'h23, 1'b0, 1'b1);
    step(1'b1, 32'h31, 1'b0, 1'b0);
    step(1'b1, 32'h32, 1'b0, 1'b0);
    step(1'b1, 32'h33, 1'b0, 1'b0);
    step(1'b0, 32'h0,  1'b1, 1'b0);
    step(1'b0, 32'h0,  1'b0, 1'b0);

    // Asynchronous reset at count 2 takes effect immediately.
    step(1'b1, 32'h41, 1'b0, 1'b0);
    step(1'b1, 32'h42, 1'b0, 1'b0);
    @(negedge clk);
    word_valid = 1'b0;
    #2;
    n_rst = 1'b0;
    #1;
    check("async_rst_word_count",   32'(word_count),   32'd0);
    check("async_rst_opcode_valid", 32'(opcode_valid), 32'd0);
    check("async_rst_op_count",     32'(op_count),     32'd0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;

    // One word then idle: times out only when the option is built in.
    step(1'b1, 32'h51, 1'b0, 1'b0);
    for (int i = 0; i < 2 * TMO + 2; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
`ifdef OPCODE_LOADER_TIMEOUT_EN
    check("timeout_word_count", 32'(word_count), 32'd0);
`else
    check("no_timeout_word_count", 32'(word_count), 32'd1);
`endif
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7,
           $urandom(),
           $urandom_range(0, 9) < 4,
           $urandom_range(0, 39) == 0);
    end
    step(1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/opcode_loader.md
# opcode_loader

Sequencing controller for the GPU's 3-word opcode shift register. Accepts 32-bit instruction words from the command FIFO over a valid/ready handshake and drives the register's `shift_enable`/`serial_in`. After every third word it flags a complete 96-bit opcode to the decoder and holds it until the decoder accepts. Sits between the command FIFO and the opcode register / decoder pair.

## Interface
- `WORD_W`, 32, width of one instruction word and of `serial_out`.
- `WORDS_PER_OP`, 3, words per opcode; the count register is 2 bits wide.
- `TIMEOUT_CYCLES`, 255, idle cycles allowed between words of a partial opcode. Used only with `OPCODE_LOADER_TIMEOUT_EN`. Range 1..65535.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `word_valid`  in  1  FIFO presents a word on `word_in`.
- `word_in`  in  WORD_W  instruction word.
- `word_ready`  out  1  the loader will take `word_in` this cycle.
- `shift_enable`  out  1  to the opcode register; equals `word_valid && word_ready`.
- `serial_out`  out  WORD_W  to the opcode register's `serial_in`; combinational pass-through of `word_in`.
- `opcode_valid`  out  1  the opcode register holds a complete opcode.
- `opcode_accept`  in  1  decoder consumes the opcode; only meaningful while `opcode_valid`=1.
- `flush`  in  1  synchronous abort of any partial or complete opcode.
- `word_count`  out  2  words held in the current partial opcode, 0..2.
- `op_count`  out  16  complete opcodes accepted by the decoder since reset; wraps.
- `frame_error`  out  1  one-cycle pulse when a partial opcode is discarded by timeout.

## Operation
- States:
  - IDLE: `word_count`=0.
  - LOAD: 1..2 words held.
  - FULL: 3 words held, `opcode_valid`=1.
- Handshake: a word transfers on a rising edge where `word_valid && word_ready`.
- `word_ready`:
  - IDLE and LOAD: equals `!flush`.
  - FULL: equals `opcode_accept && !flush`.
- Transitions:
  - IDLE + transfer → LOAD, count 1.
  - LOAD + transfer: count 1 → 2, or count 2 → FULL with count 0.
  - FULL + `opcode_accept`:
    - with a transfer → LOAD, count 1. The register shifts on the same edge the decoder samples, so back-to-back opcodes carry no bubble.
    - without a transfer → IDLE.
- `op_count` increments on every edge where FULL and `opcode_accept`=1. 0xFFFF wraps to 0x0000.
- `flush`=1 (any state) → IDLE, count 0, `opcode_valid`=0 from the next cycle. Flush has priority over transfer and over accept:
  - no shift occurs;
  - `op_count` is unchanged;
  - register contents are left stale and are not cleared.
- `opcode_accept` while not FULL is ignored.
- Reset values: state IDLE, `word_count`=0, `opcode_valid`=0, `op_count`=0, `frame_error`=0, timeout counter 0.
  - `word_ready` resets to 1 and `shift_enable` follows `word_valid`.
  - Reset mid-opcode discards the partial opcode. The register itself resets to all-ones independently.

## Timing
- `opcode_valid` rises the cycle after the edge that shifts the third word in.
- `word_ready`, `shift_enable` and `serial_out` are combinational from `word_valid`, `word_in`, `opcode_accept`, `flush` and state. There is no registered delay.
- `opcode_valid`, `word_count`, `op_count` and `frame_error` are registered.
- Sustained throughput is one word per cycle, i.e. one opcode per 3 cycles.

## Configuration
- `OPCODE_LOADER_TIMEOUT_EN` defined:
  - A 16-bit counter runs in LOAD. It clears on every transfer and increments on every cycle without one.
  - When it reaches `TIMEOUT_CYCLES`, the next edge moves to IDLE with count 0, clears the counter and pulses `frame_error` for exactly one cycle.
  - `flush` on that same edge also returns to IDLE but suppresses `frame_error`.
  - The counter is held at 0 in IDLE and FULL.
- `OPCODE_LOADER_TIMEOUT_EN` undefined: no counter; `frame_error` is tied to 0; partial opcodes wait indefinitely.

## Test plan
- Reset, then `word_valid`=1 with words 0xA, 0xB, 0xC on 3 consecutive cycles, `opcode_accept`=0 → 3 `shift_enable` pulses. `opcode_valid`=1 on cycle 4 and holds. `word_ready`=0 while FULL.
- While FULL, hold `opcode_accept`=1 and `word_valid`=1 with words 0xD, 0xE, 0xF → shift on the accept edge, `word_count`=1, `op_count`=1. `opcode_valid` goes 0 for exactly 2 cycles, then 1 again.
- After 2 words, assert `flush` together with `word_valid` → no shift, `word_count`=0, and the next 3 words form a fresh opcode.
- FULL with `opcode_accept` and `flush` asserted together → IDLE, `op_count` unchanged, `opcode_valid`=0.
- Assert `n_rst`=0 at count 2 → `word_count`=0 and `opcode_valid`=0 immediately. `op_count` clears to 0.
- With `OPCODE_LOADER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=4: send 1 word, then idle → `frame_error` is a 1-cycle pulse 5 cycles after the transfer edge, then `word_count`=0. Without the macro, `frame_error` stays 0 and `word_count` holds 1.
